// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment capture path: legal
// active-low segment patterns ({g,f,e,d,c,b,a}), anode codes and FSM states.
package seg7_pkg;

   localparam logic [6:0] SEG7_0 = 7'b1000000;
   localparam logic [6:0] SEG7_1 = 7'b1111001;
   localparam logic [6:0] SEG7_2 = 7'b0100100;
   localparam logic [6:0] SEG7_3 = 7'b0110000;
   localparam logic [6:0] SEG7_4 = 7'b0011001;
   localparam logic [6:0] SEG7_5 = 7'b0010010;
   localparam logic [6:0] SEG7_6 = 7'b0000010;
   localparam logic [6:0] SEG7_7 = 7'b1111000;
   localparam logic [6:0] SEG7_8 = 7'b0000000;
   localparam logic [6:0] SEG7_9 = 7'b0010000;
   localparam logic [6:0] SEG7_A = 7'b0001000;
   localparam logic [6:0] SEG7_B = 7'b0000011;
   localparam logic [6:0] SEG7_C = 7'b1000110;
   localparam logic [6:0] SEG7_D = 7'b0100001;
   localparam logic [6:0] SEG7_E = 7'b0000110;
   localparam logic [6:0] SEG7_F = 7'b0001110;

   // Active-low digit enables
   localparam logic [1:0] AN_LO  = 2'b10;
   localparam logic [1:0] AN_HI  = 2'b01;
   localparam logic [1:0] AN_OFF = 2'b11;

   typedef enum logic [0:0] {
      HUNT_LO = 1'b0,
      WAIT_HI = 1'b1
   } seg7_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern to hex nibble decoder; ok is low for any
// pattern outside the 16 legal digit shapes.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       ok
);

   // Reverse lookup of the active-low segment pattern
   always_comb begin
      nibble = 4'h0;
      ok     = 1'b1;
      case (seg)
         SEG7_0:  nibble = 4'h0;
         SEG7_1:  nibble = 4'h1;
         SEG7_2:  nibble = 4'h2;
         SEG7_3:  nibble = 4'h3;
         SEG7_4:  nibble = 4'h4;
         SEG7_5:  nibble = 4'h5;
         SEG7_6:  nibble = 4'h6;
         SEG7_7:  nibble = 4'h7;
         SEG7_8:  nibble = 4'h8;
         SEG7_9:  nibble = 4'h9;
         SEG7_A:  nibble = 4'hA;
         SEG7_B:  nibble = 4'hB;
         SEG7_C:  nibble = 4'hC;
         SEG7_D:  nibble = 4'hD;
         SEG7_E:  nibble = 4'hE;
         SEG7_F:  nibble = 4'hF;
         default: ok = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_capture.sv
// Receive-side capture of a multiplexed two-digit 7-segment bus. Synchronises
// seg/an, waits for STABLE_CYCLES identical samples, decodes the digit and
// assembles {high, low} into value with a one-cycle valid strobe.
// Optional: SEG7_CAPTURE_CHANGE_ONLY_EN suppresses valid for an unchanged byte
// (the first capture after reset always pulses).
module seg7_capture
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] seg,
   input  logic [1:0] an,
   output logic [7:0] value,
   output logic       valid,
   output logic       err
);

   localparam logic [7:0] STABLE_LIM = STABLE_CYCLES[7:0];

   logic [8:0]  sync1_q, sync2_q, prev_q;
   logic [7:0]  cnt_q, cnt_d;
   logic        accept;
   logic [3:0]  nibble;
   logic        ok;
   logic [6:0]  samp_seg;
   logic [1:0]  samp_an;

   seg7_state_t state_q, state_d;
   logic [3:0]  lo_q, lo_d;
   logic [7:0]  value_q, value_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;
`ifdef SEG7_CAPTURE_CHANGE_ONLY_EN
   logic        first_q, first_d;
`endif

   assign samp_seg = sync2_q[6:0];
   assign samp_an  = sync2_q[8:7];

   // Two-flop synchroniser plus previous-sample register; idle is all-off (1s)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
         prev_q  <= '1;
      end else begin
         sync1_q <= {an, seg};
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Stability counter; accept fires only on the cycle it reaches the limit
   always_comb begin
      cnt_d = cnt_q;
      if (sync2_q != prev_q) begin
         cnt_d = 8'd0;
      end else if (cnt_q != STABLE_LIM) begin
         cnt_d = cnt_q + 8'd1;
      end
      accept = (cnt_d == STABLE_LIM) && (cnt_q != STABLE_LIM) &&
               ((samp_an == AN_LO) || (samp_an == AN_HI));
   end

   seg7_decode u_decode (
      .seg    (samp_seg),
      .nibble (nibble),
      .ok     (ok)
   );

   // Capture FSM next-state and registered-output logic
   always_comb begin
      state_d = state_q;
      lo_d    = lo_q;
      value_d = value_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
`ifdef SEG7_CAPTURE_CHANGE_ONLY_EN
      first_d = first_q;
`endif
      if (accept) begin
         if (!ok) begin
            err_d   = 1'b1;
            state_d = HUNT_LO;
         end else begin
            case (state_q)
               HUNT_LO: begin
                  if (samp_an == AN_LO) begin
                     lo_d    = nibble;
                     state_d = WAIT_HI;
                  end
               end
               WAIT_HI: begin
                  if (samp_an == AN_LO) begin
                     lo_d = nibble;
                  end else begin
                     value_d = {nibble, lo_q};
                     state_d = HUNT_LO;
`ifdef SEG7_CAPTURE_CHANGE_ONLY_EN
                     valid_d = first_q || ({nibble, lo_q} != value_q);
                     first_d = 1'b0;
`else
                     valid_d = 1'b1;
`endif
                  end
               end
               default: state_d = HUNT_LO;
            endcase
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= 8'd0;
         state_q <= HUNT_LO;
         lo_q    <= 4'h0;
         value_q <= 8'h00;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
`ifdef SEG7_CAPTURE_CHANGE_ONLY_EN
         first_q <= 1'b1;
`endif
      end else begin
         cnt_q   <= cnt_d;
         state_q <= state_d;
         lo_q    <= lo_d;
         value_q <= value_d;
         valid_q <= valid_d;
         err_q   <= err_d;
`ifdef SEG7_CAPTURE_CHANGE_ONLY_EN
         first_q <= first_d;
`endif
      end
   end

   assign value = value_q;
   assign valid = valid_q;
   assign err   = err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed table-driven bench for seg7_capture (STABLE_CYCLES = 4).
module tb_seg7_capture;
   import seg7_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [6:0] seg;
   logic [1:0] an;
   logic [7:0] value;
   logic       valid;
   logic       err;

   int n_cmp  = 0;
   int n_fail = 0;
   int vcnt   = 0;
   int ecnt   = 0;

   seg7_capture #(.STABLE_CYCLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .seg   (seg),
      .an    (an),
      .value (value),
      .valid (valid),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Pulse counting and mutual-exclusion of valid/err
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid) vcnt++;
         if (err) ecnt++;
         if (valid || err) check("valid_err_exclusive", int'(valid & err), 0);
      end
   end

   // Called just after a rising edge; holds the pattern for n cycles
   task automatic hold(input logic [1:0] a, input logic [6:0] s, input int n);
      an  = a;
      seg = s;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic capture(input logic [6:0] lo_s, input logic [6:0] hi_s);
      hold(AN_LO, lo_s, 10);
      hold(AN_HI, hi_s, 10);
      hold(AN_OFF, 7'h7F, 10);
   endtask

   typedef struct {
      logic [6:0] lo_seg;
      logic [6:0] hi_seg;
      logic [7:0] exp_value;
      int         exp_valid;
      int         exp_err;
   } vec_t;

   vec_t vecs[9];
   int   lat;

   initial begin
      vecs[0] = '{SEG7_1, SEG7_F, 8'hF1, 1, 0};
      vecs[1] = '{SEG7_2, SEG7_E, 8'hE2, 1, 0};
      vecs[2] = '{SEG7_3, SEG7_4, 8'h43, 1, 0};
      vecs[3] = '{SEG7_5, SEG7_6, 8'h65, 1, 0};
      vecs[4] = '{SEG7_7, SEG7_8, 8'h87, 1, 0};
      vecs[5] = '{SEG7_9, SEG7_A, 8'hA9, 1, 0};
      vecs[6] = '{SEG7_B, SEG7_C, 8'hCB, 1, 0};
      vecs[7] = '{SEG7_D, SEG7_0, 8'h0D, 1, 0};
      vecs[8] = '{SEG7_1, 7'h7F,  8'h0D, 0, 1};

      rst_n = 1'b0;
      an    = AN_OFF;
      seg   = 7'h7F;
      repeat (3) @(posedge clk);
      #1;
      check("reset_value", int'(value), 8'h00);
      check("reset_valid", int'(valid), 0);
      check("reset_err", int'(err), 0);
      rst_n = 1'b1;
      hold(AN_OFF, 7'h7F, 5);

      // Table: every legal digit shape plus one illegal high digit
      for (int i = 0; i < 9; i++) begin
         vcnt = 0;
         ecnt = 0;
         capture(vecs[i].lo_seg, vecs[i].hi_seg);
         check($sformatf("vec%0d_value", i), int'(value), int'(vecs[i].exp_value));
         check($sformatf("vec%0d_valid_cnt", i), vcnt, vecs[i].exp_valid);
         check($sformatf("vec%0d_err_cnt", i), ecnt, vecs[i].exp_err);
      end

      // After the illegal digit the FSM hunts: a lone high digit does nothing
      vcnt = 0;
      hold(AN_HI, SEG7_5, 10);
      hold(AN_OFF, 7'h7F, 10);
      check("after_err_hunt_valid", vcnt, 0);
      check("after_err_hunt_value", int'(value), 8'h0D);

      // Glitch on the high digit: acceptance restarts from the restored value
      vcnt = 0;
      hold(AN_LO, SEG7_2, 10);
      hold(AN_HI, SEG7_E, 3);
      hold(AN_HI, SEG7_8, 1);
      seg = SEG7_E;
      lat = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (valid && lat < 0) lat = k;
      end
      @(posedge clk);
      #1;
      check("glitch_latency", lat, 7);
      check("glitch_valid_cnt", vcnt, 1);
      check("glitch_value", int'(value), 8'hE2);

      // Lone high digit "1" in HUNT_LO is ignored
      vcnt = 0;
      hold(AN_OFF, 7'h7F, 10);
      hold(AN_HI, SEG7_1, 10);
      hold(AN_OFF, 7'h7F, 10);
      check("lone_hi_valid_cnt", vcnt, 0);
      check("lone_hi_value", int'(value), 8'hE2);

      // Reset while in WAIT_HI clears value immediately
      hold(AN_LO, SEG7_1, 10);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_value", int'(value), 8'h00);
      check("midrst_valid", int'(valid), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      vcnt = 0;
      ecnt = 0;
      hold(AN_HI, SEG7_F, 10);
      hold(AN_OFF, 7'h7F, 10);
      check("postrst_hi_only_valid", vcnt, 0);
      check("postrst_hi_only_err", ecnt, 0);
      capture(SEG7_1, SEG7_F);
      check("postrst_capture_valid", vcnt, 1);
      check("postrst_capture_value", int'(value), 8'hF1);

      // First capture after reset pulses even for 00; then F1 twice
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      vcnt = 0;
      capture(SEG7_0, SEG7_0);
      check("first_zero_valid", vcnt, 1);
      check("first_zero_value", int'(value), 8'h00);
      vcnt = 0;
      capture(SEG7_1, SEG7_F);
      capture(SEG7_1, SEG7_F);
      check("repeat_value", int'(value), 8'hF1);
`ifdef SEG7_CAPTURE_CHANGE_ONLY_EN
      check("repeat_valid_cnt", vcnt, 1);
`else
      check("repeat_valid_cnt", vcnt, 2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Sequential decoder for the board's multiplexed two-digit 7-segment bus: the receive-side counterpart of the binary-to-7-segment display drivers. It samples segment and anode lines, filters digit-switch glitches, maps each stable segment pattern back to a hex nibble, and outputs the reconstructed byte with a one-cycle valid strobe. It sits in loopback/self-check designs between a display driver's pins and comparison logic.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical synchronised samples needed to accept a digit (legal range 1–255).
- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `seg` in 7: segment lines, active-low, bit order {g,f,e,d,c,b,a}.
- `an` in 2: digit enables, active-low; `an[0]` = low nibble digit, `an[1]` = high nibble digit.
- `value` out 8: last complete captured byte {high, low}.
- `valid` out 1: one-cycle pulse when `value` updates.
- `err` out 1: one-cycle pulse on a stable, enabled, unrecognised segment pattern.

## Operation
- `seg`/`an` pass through a 2-flop synchroniser; every later stage sees only synchronised samples.
- Stability counter: it resets to 0 when the 9-bit sample differs from the previous cycle and increments otherwise, saturating at `STABLE_CYCLES`.
- A digit is accepted once per steady period, on the cycle the counter reaches `STABLE_CYCLES`. It re-arms only after the sample changes.
- `an` = 2'b11 (blank) or 2'b00 (both on) is never accepted.
- Decode: there are 16 legal active-low patterns, including 0=1000000, 1=1111001, 2=0100100, E=0000110, F=0001110. Any other pattern is illegal.
- FSM states:
  - HUNT_LO: an accepted low digit stores its nibble and moves to WAIT_HI. An accepted high digit is ignored.
  - WAIT_HI: an accepted high digit loads `value` <= {hi, stored lo}, pulses `valid`, and returns to HUNT_LO. An accepted low digit overwrites the stored nibble and stays in WAIT_HI.
- An illegal pattern accepted in either state pulses `err`, leaves `value` unchanged, and returns to HUNT_LO.
- Reset (at any time, including mid-capture): `value`=8'h00, `valid`=0, `err`=0, state HUNT_LO, counter 0, synchroniser flops 1 (idle, all off).

## Timing
- Outputs are registered. `valid`/`err` assert the cycle after the accepting cycle and last exactly one cycle.
- From an input change to acceptance: 2 (sync) + `STABLE_CYCLES` cycles. `valid` follows 1 cycle later.
- Back-to-back: a new `valid` may occur on any cycle after a full low+high sequence. There is no minimum gap beyond the stability requirement.
- `err` and `valid` are never high in the same cycle.

## Configuration
- `SEG7_CAPTURE_CHANGE_ONLY_EN` defined:
  - `valid` pulses only when the new byte differs from the current `value`.
  - An identical byte still completes the FSM sequence without a pulse.
  - The first capture after reset always pulses, even for 8'h00.
- Undefined: every completed sequence pulses `valid`.

## Structure
- Shared package `seg7_pkg`:
  - legal pattern constants `SEG7_0`…`SEG7_F`;
  - FSM state typedef (HUNT_LO, WAIT_HI);
  - anode constants `AN_LO`=2'b10, `AN_HI`=2'b01, `AN_OFF`=2'b11.
- One sub-module `seg7_decode`: combinational pattern→{nibble, ok}, reusable by other checkers.

## Test plan
- Hold `an`=10 with `seg`=1111001 and then `an`=01 with `seg`=0001110, each for 10 cycles -> one `valid` pulse with `value`=8'hF1.
- Low digit "2", then high digit "E" -> `value`=8'hE2. Then present high "1" alone -> no pulse, `value` stays 8'hE2.
- 1-cycle glitch on `seg` mid-digit with `STABLE_CYCLES`=4 -> no acceptance until 4 steady cycles after the glitch. There is no spurious `valid`.
- Low "1" then high with `seg`=1111111 (illegal) -> `err` pulse, `value` unchanged, FSM back in HUNT_LO.
- Assert `rst_n` low while in WAIT_HI -> `value`=8'h00 and `valid`=0 immediately. Next capture needs a fresh low digit.
- With `SEG7_CAPTURE_CHANGE_ONLY_EN`: capture 8'hF1 twice -> exactly one `valid` pulse. Without it -> two pulses.
